// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hazard/stall controller for the 5-stage MIPS pipeline.
// Drives the PC, IF/ID and ID/EX enables and flushes, and the EX/MEM bubble.
// It handles load-use stalls and taken-branch flushes. It also sequences
// multi-cycle MULT/DIV occupancy of EX with a small FSM and a countdown counter.
// Optional build macro HAZ_PERF_CNT_EN adds saturating stall/flush event
// counters. When the macro is undefined, stall_cnt and flush_cnt read 0.
module pipe_hazard_ctrl #(
  parameter int MD_LAT = 8,   // MULT/DIV occupancy of EX in cycles (2..63)
  parameter int CNT_W  = 6    // countdown width, must hold MD_LAT-1
) (
  input  logic        clk,
  input  logic        reset,         // async, active-low
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_use_rt,
  input  logic        idex_memread,
  input  logic [4:0]  idex_rt,
  input  logic        ex_br_taken,
  input  logic        ex_md_start,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        ifid_flush,
  output logic        idex_en,
  output logic        idex_flush,
  output logic        exmem_bubble,
  output logic        md_busy,
  output logic        md_done,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] MD_LOAD = CNT_W'(MD_LAT - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             lu;

  // Load-use: the load in EX writes a non-zero register that ID reads.
  assign lu = idex_memread && (idex_rt != 5'd0) &&
              ((idex_rt == id_rs) || (id_use_rt && (idex_rt == id_rt)));

  // State register; reset aborts any MULT/DIV in flight without a done pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state: start is only honoured in IDLE, even alongside a taken branch
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ex_md_start) state_nxt = MD_BUSY;
      MD_BUSY: if (cnt == '0)   state_nxt = MD_DONE;
      MD_DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Countdown: load MD_LAT-1 on start so MD_BUSY lasts exactly MD_LAT cycles; holds at 0
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                              cnt <= '0;
    else if (state == IDLE && ex_md_start)   cnt <= MD_LOAD;
    else if (state == MD_BUSY && cnt != '0)  cnt <= cnt - CNT_W'(1);
  end

  // Outputs: combinational from state and inputs in priority order; all zero in reset
  always_comb begin
    pc_en        = 1'b0;
    ifid_en      = 1'b0;
    ifid_flush   = 1'b0;
    idex_en      = 1'b0;
    idex_flush   = 1'b0;
    exmem_bubble = 1'b0;
    md_busy      = 1'b0;
    md_done      = 1'b0;
    if (reset) begin
      if (state == MD_BUSY) begin
        // EX is occupied: freeze the front end and bubble EX/MEM.
        exmem_bubble = 1'b1;
        md_busy      = 1'b1;
      end else begin
        pc_en   = 1'b1;
        ifid_en = 1'b1;
        idex_en = 1'b1;
        md_done = (state == MD_DONE);
        if (ex_br_taken) begin
          // The instruction in ID is on the wrong path, so a load-use hit there is moot.
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
        end else if (lu) begin
          pc_en      = 1'b0;
          ifid_en    = 1'b0;
          idex_flush = 1'b1;
        end
      end
    end
  end

`ifdef HAZ_PERF_CNT_EN
  // Stall-cycle counter, saturating; reset cycles are not counted
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                            stall_cnt <= '0;
    else if (!pc_en && stall_cnt != '1)    stall_cnt <= stall_cnt + 32'd1;
  end

  // Flush-event counter, saturating
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                            flush_cnt <= '0;
    else if (ifid_flush && flush_cnt != '1) flush_cnt <= flush_cnt + 32'd1;
  end
`else
  assign stall_cnt = 32'd0;
  assign flush_cnt = 32'd0;
`endif

endmodule
